// File: rtl/p32_mod_subtractor_pipe.sv
// ============================================================================
// Module   : p32_mod_subtractor_pipe
// Brief    : Two-stage valid/ready modulo-(2^N-1) subtractor, diff = a + ~b
//            with end-around carry from a cyclic prefix network; carries a tag.
//            Optional macro P32_SUB_ZERO_NORM_EN maps all-ones results to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module p32_mod_subtractor_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     diff,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int C_LVLS = $clog2(N);

    // Stage S1: bitwise generate/propagate/half-sum of a and ~b
    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_g_q, s1_g_d;
    logic [N-1:0]     s1_p_q, s1_p_d;
    logic [N-1:0]     s1_x_q, s1_x_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage S2: final result
    logic             s2_valid_q, s2_valid_d;
    logic [N-1:0]     s2_diff_q, s2_diff_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             w_s1_adv;
    logic [N-1:0]     w_bc;
    logic [N-1:0]     w_gcyc;
    logic [N-1:0]     w_diff_raw;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int sh);
        return (v << sh) | (v >> (N - sh));
    endfunction

    assign w_s1_adv = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || w_s1_adv;
    assign w_bc     = ~b;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_x_d     = s1_x_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_g_d   = a & w_bc;
                s1_p_d   = a | w_bc;
                s1_x_d   = a ^ w_bc;
                s1_tag_d = in_tag;
            end
        end
    end

    // Cyclic prefix: each level wraps the carry around the MSB, so after
    // log2(N) levels every bit sees the full circle and the end-around carry.
    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        g = s1_g_q;
        p = s1_p_q;
        for (int k = 0; k < C_LVLS; k++) begin
            g = g | (p & rotl(g, 1 << k));
            if (k < C_LVLS - 1) begin
                p = p & rotl(p, 1 << k);
            end
        end
        w_gcyc = g;
    end

    assign w_diff_raw = s1_x_q ^ {w_gcyc[N-2:0], w_gcyc[N-1]};

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_tag_d   = s2_tag_q;
        if (w_s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef P32_SUB_ZERO_NORM_EN
                s2_diff_d = (&w_diff_raw) ? '0 : w_diff_raw;
`else
                s2_diff_d = w_diff_raw;
`endif
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_x_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_x_q     <= s1_x_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = s2_diff_q;
    assign out_tag   = s2_tag_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_p32_mod_subtractor_pipe.sv
// ============================================================================
// Module   : tb_p32_mod_subtractor_pipe
// Brief    : Vector table, stall/reset sequences and random stream against a
//            queued reference model for p32_mod_subtractor_pipe (N=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p32_mod_subtractor_pipe;

    localparam int N     = 32;
    localparam int TAG_W = 4;
    localparam logic [N-1:0] C_ONES = '1;
`ifdef P32_SUB_ZERO_NORM_EN
    localparam bit C_NORM = 1'b1;
`else
    localparam bit C_NORM = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     diff;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    p32_mod_subtractor_pipe #(.N(N), .TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [N-1:0]     exp;
        bit               exact;
        int               acc_cyc;
        bit               chk_lat;
    } sb_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        bit           exact;
    } vec_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  rdy_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [N-1:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [63:0] m, xm, ym;
        m  = 64'h0000_0000_FFFF_FFFF;
        xm = {32'd0, x} % m;
        ym = {32'd0, y} % m;
        return 32'((xm - ym + m) % m);
    endfunction

    function automatic bit match(input logic [N-1:0] act, input logic [N-1:0] exp, input bit exact);
        if (exact || C_NORM) return act === exp;
        return (act === exp) || (exp == '0 && act === C_ONES);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: pops the scoreboard on each beat and checks held data.
    initial begin
        sb_t              e;
        bit               hold_pend;
        logic [N-1:0]     hold_d;
        logic [TAG_W-1:0] hold_t;
        hold_pend = 1'b0;
        hold_d    = '0;
        hold_t    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    checks++;
                    if (!out_valid || diff !== hold_d || out_tag !== hold_t) begin
                        failures++;
                        $display("FAIL hold: valid=%0b diff=%h tag=%h, required valid=1 diff=%h tag=%h",
                                 out_valid, diff, out_tag, hold_d, hold_t);
                    end
                end
                hold_pend = 1'b0;
                if (out_valid && out_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat: diff=%h tag=%h, required no beat", diff, out_tag);
                    end else begin
                        e = sbq.pop_front();
                        if (out_tag !== e.tag || !match(diff, e.exp, e.exact)) begin
                            failures++;
                            $display("FAIL result: diff=%h tag=%h, required diff=%h tag=%h",
                                     diff, out_tag, e.exp, e.tag);
                        end
                        if (e.chk_lat) begin
                            checks++;
                            if (cyc - e.acc_cyc != 2) begin
                                failures++;
                                $display("FAIL latency: got %0d cycles, required 2", cyc - e.acc_cyc);
                            end
                        end
                    end
                end else if (out_valid) begin
                    hold_pend = 1'b1;
                    hold_d    = diff;
                    hold_t    = out_tag;
                end
            end
        end
    end

    // Call just after a posedge; returns just after the posedge that accepts.
    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic [TAG_W-1:0] vt,
                        input logic [N-1:0] vexp, input bit vexact, input bit vlat);
        sb_t e;
        bit  acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        in_tag   = vt;
        for (int w = 0; w < 1000 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag     = vt;
                e.exp     = vexp;
                e.exact   = vexact;
                e.acc_cyc = cyc;
                e.chk_lat = vlat;
                sbq.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%0b, required 1 within 1000 cycles", in_ready);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int w = 0; w < 2000 && !done; w++) begin
            @(posedge clk);
            #1;
            if (sbq.size() == 0 && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain: %0d results outstanding busy=%0b, required 0 and 0", sbq.size(), busy);
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [N-1:0] ra, rb;
        int           stalls;
        int           sel;

        vecs[0] = '{32'd5,          32'd3,          32'h0000_0002, 1'b1};
        vecs[1] = '{32'd3,          32'd5,          32'hFFFF_FFFD, 1'b1};
        vecs[2] = '{32'h1234_5678,  32'h1234_5678,  C_NORM ? 32'h0 : 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'd0,          32'd0,          32'h0000_0000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd0,          32'h0000_0000, 1'b0};
        vecs[5] = '{32'd0,          32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD, 1'b1};
        vecs[7] = '{32'd1,          32'hFFFF_FFFE,  32'h0000_0002, 1'b1};
        vecs[8] = '{32'h8000_0000,  32'h7FFF_FFFF,  32'h0000_0001, 1'b1};
        vecs[9] = '{32'd0,          32'd1,          32'hFFFF_FFFE, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%0b busy=%0b diff=%h tag=%h, required all 0",
                     out_valid, busy, diff, out_tag);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%0b, required 1", in_ready);
        end

        // Isolated directed vectors with latency checks
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].exp, vecs[i].exact, 1'b1);
            drain();
        end

        // Stream 8 ops with out_ready low for cycles 3..6
        rdy_mode = 2;
        stalls   = 0;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    ra = $urandom();
                    rb = $urandom();
                    send(ra, rb, TAG_W'(t), ref_sub(ra, rb), 1'b0, 1'b0);
                end
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    if (!in_ready) stalls++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        rdy_mode = 0;
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL stall_backpressure: in_ready low for %0d cycles, required >0", stalls);
        end

        // Reset with two ops in flight
        send(32'd100, 32'd1, 4'd9,  32'd99, 1'b1, 1'b0);
        send(32'd200, 32'd2, 4'd10, 32'd198, 1'b1, 1'b0);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_inflight: busy=%0b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%0b busy=%0b, required 0 0", out_valid, busy);
        end
        sbq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(32'd7, 32'd9, 4'd3, 32'hFFFF_FFFD, 1'b1, 1'b1);
        drain();

        // Random stream with random backpressure against the reference model
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom();
            rb  = $urandom();
            if (sel == 0)      ra = C_ONES;
            else if (sel == 1) rb = C_ONES;
            else if (sel == 2) rb = ra;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(ra, rb, TAG_W'(i), ref_sub(ra, rb), 1'b0, 1'b0);
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
